// File: rtl/sha_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and the sigma/Sigma helpers.
package sha_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_FINAL,
        ST_DONE
    } sha_state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam HashState IV = HashState'(256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19);

    // Padding for re-hashing a 256-bit digest: leading 1 bit, then length = 256 bits.
    localparam logic [31:0] PAD2_FIRST = 32'h8000_0000;
    localparam logic [31:0] PAD2_LEN   = 32'h0000_0100;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic HashState add_state(input HashState x, input HashState y);
        HashState s;
        s.a = x.a + y.a;
        s.b = x.b + y.b;
        s.c = x.c + y.c;
        s.d = x.d + y.d;
        s.e = x.e + y.e;
        s.f = x.f + y.f;
        s.g = x.g + y.g;
        s.h = x.h + y.h;
        return s;
    endfunction

endpackage

// File: rtl/sha_multiblock_core_round.sv
// One combinational SHA-256 compression round: working variables in, working variables out.
module sha_round_step
    import sha_pkg::*;
(
    input  HashState    i_state,
    input  logic [31:0] i_w,
    input  logic [31:0] i_k,
    output HashState    o_state
);
    logic [31:0] w_t1;
    logic [31:0] w_t2;

    assign w_t1 = i_state.h + bsig1(i_state.e) + ch(i_state.e, i_state.f, i_state.g) + i_k + i_w;
    assign w_t2 = bsig0(i_state.a) + maj(i_state.a, i_state.b, i_state.c);

    always_comb begin
        o_state.a = w_t1 + w_t2;
        o_state.b = i_state.a;
        o_state.c = i_state.b;
        o_state.d = i_state.c;
        o_state.e = i_state.d + w_t1;
        o_state.f = i_state.e;
        o_state.g = i_state.f;
        o_state.h = i_state.g;
    end

endmodule

// File: rtl/sha_multiblock_core.sv
// SHA-256 over 1..MAX_BLOCKS pre-padded blocks, one round per clock, with optional in-core sha256d.
// States: IDLE wait for start | LOAD rounds 0..15 on fed words | EXPAND rounds 16..63 | FINAL add into H | DONE hold digest
module sha_multiblock_core
    import sha_pkg::*;
#(
    parameter int MAX_BLOCKS = 2,
    parameter int BLKW       = 2,
    parameter bit DOUBLE     = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BLKW-1:0] nblocks,
    input  logic            dbl,
    output logic            busy,
    input  logic            m_valid,
    output logic            m_ready,
    input  logic [31:0]     M,
    output HashState        hash,
    output logic            hash_valid,
    input  logic            hash_ready
);
    sha_state_e      r_state;
    sha_state_e      w_next;
    logic [5:0]      r_t;
    logic [BLKW-1:0] r_blk;
    logic [BLKW-1:0] r_nblk;
    logic [BLKW-1:0] w_nblk_eff;
    logic            r_dbl;
    logic            r_pass2;
    HashState        r_h;
    HashState        r_work;
    HashState        r_hash;
    HashState        w_work_next;
    HashState        w_h_sum;
    logic [31:0]     r_win [16];
    logic [31:0]     w_word;
    logic [255:0]    w_dig;
    logic            w_step;
    logic            w_start_ok;
    logic            w_more_blk;

    assign hash       = r_hash;
    assign w_h_sum    = add_state(r_h, r_work);
    assign w_dig      = w_h_sum;
    assign w_start_ok = start && (r_state == ST_IDLE || (r_state == ST_DONE && hash_ready));
    assign w_more_blk = (int'(r_blk) + 1) < int'(r_nblk);
    assign w_step     = (r_state == ST_LOAD && (r_pass2 || m_valid)) || r_state == ST_EXPAND;

    always_comb begin
        w_nblk_eff = nblocks;
        if (nblocks == '0)
            w_nblk_eff = BLKW'(1);
        else if (int'(nblocks) > MAX_BLOCKS)
            w_nblk_eff = BLKW'(MAX_BLOCKS);
    end

    // Second pass words sit in the window and are rotated out of slot 0 one per round.
    always_comb begin
        w_word = M;
        if (r_state == ST_EXPAND)
            w_word = ssig1(r_win[14]) + r_win[9] + ssig0(r_win[1]) + r_win[0];
        else if (r_pass2)
            w_word = r_win[0];
    end

    sha_round_step u_round (
        .i_state (r_work),
        .i_w     (w_word),
        .i_k     (K[r_t]),
        .o_state (w_work_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        busy       = (r_state != ST_IDLE);
        m_ready    = 1'b0;
        hash_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_next = ST_LOAD;
            end
            ST_LOAD: begin
                m_ready = !r_pass2;
                if (w_step && r_t == 6'd15)
                    w_next = ST_EXPAND;
            end
            ST_EXPAND: begin
                if (r_t == 6'd63)
                    w_next = ST_FINAL;
            end
            ST_FINAL: begin
                if (w_more_blk || (r_dbl && !r_pass2))
                    w_next = ST_LOAD;
                else
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                hash_valid = 1'b1;
                if (hash_ready)
                    w_next = start ? ST_LOAD : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_t     <= '0;
            r_blk   <= '0;
            r_nblk  <= '0;
            r_dbl   <= 1'b0;
            r_pass2 <= 1'b0;
            r_h     <= '0;
            r_work  <= '0;
            r_hash  <= '0;
            for (int i = 0; i < 16; i++)
                r_win[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_nblk  <= w_nblk_eff;
                        r_dbl   <= DOUBLE && dbl;
                        r_pass2 <= 1'b0;
                        r_h     <= IV;
                        r_work  <= IV;
                        r_t     <= '0;
                        r_blk   <= '0;
                    end
                end
                ST_LOAD, ST_EXPAND: begin
                    if (w_step) begin
                        r_work <= w_work_next;
                        r_t    <= r_t + 6'd1;
                        for (int i = 0; i < 15; i++)
                            r_win[i] <= r_win[i + 1];
                        r_win[15] <= w_word;
                    end
                end
                ST_FINAL: begin
                    r_h <= w_h_sum;
                    r_t <= '0;
                    if (w_more_blk) begin
                        r_blk  <= r_blk + BLKW'(1);
                        r_work <= w_h_sum;
                    end else if (r_dbl && !r_pass2) begin
                        r_pass2 <= 1'b1;
                        r_h     <= IV;
                        r_work  <= IV;
                        for (int i = 0; i < 8; i++)
                            r_win[i] <= w_dig[255 - 32*i -: 32];
                        r_win[8] <= PAD2_FIRST;
                        for (int i = 9; i < 15; i++)
                            r_win[i] <= '0;
                        r_win[15] <= PAD2_LEN;
                    end else begin
                        r_hash <= w_h_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_multiblock_core.sv
// Self-checking bench: known-answer SHA-256 vectors plus randomized jobs against a textbook SHA-256 model.
module tb_sha_multiblock_core;
    import sha_pkg::*;

    localparam int MAXB = 2;
    localparam logic [255:0] IV_TB = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] ABC_H  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] ABCD_H = 256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;
    localparam logic [255:0] TWO_H  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] EMPTY_H = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  nblocks;
    logic        dbl;
    logic        busy;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] M;
    HashState    hash;
    logic        hash_valid;
    logic        hash_ready;

    logic [31:0] msg [64];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sha_multiblock_core #(.MAX_BLOCKS(MAXB), .BLKW(2), .DOUBLE(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .nblocks(nblocks), .dbl(dbl), .busy(busy),
        .m_valid(m_valid), .m_ready(m_ready), .M(M), .hash(hash),
        .hash_valid(hash_valid), .hash_ready(hash_ready)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [31:0] blk [16]);
        logic [31:0] w [64];
        logic [31:0] hh [8];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10));
        for (int i = 0; i < 8; i++) hh[i] = hin[255 - 32*i -: 32];
        v = hh;
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hh[i] + v[i];
        return hout;
    endfunction

    function automatic int eff_blocks(input int nb);
        return (nb < 1) ? 1 : ((nb > MAXB) ? MAXB : nb);
    endfunction

    function automatic logic [255:0] ref_hash(input int nb, input bit d);
        logic [255:0] h;
        logic [31:0] blk [16];
        h = IV_TB;
        for (int b = 0; b < eff_blocks(nb); b++) begin
            for (int i = 0; i < 16; i++) blk[i] = msg[16*b + i];
            h = compress(h, blk);
        end
        if (d) begin
            for (int i = 0; i < 8; i++) blk[i] = h[255 - 32*i -: 32];
            blk[8] = 32'h8000_0000;
            for (int i = 9; i < 15; i++) blk[i] = 32'h0;
            blk[15] = 32'h0000_0100;
            h = compress(IV_TB, blk);
        end
        return h;
    endfunction

    task automatic set_abc();
        for (int i = 0; i < 64; i++) msg[i] = 32'h0;
        msg[0] = 32'h61626380;
        msg[15] = 32'h00000018;
    endtask

    task automatic set_two();
        logic [31:0] words [14] = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
            32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e,
            32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071};
        for (int i = 0; i < 64; i++) msg[i] = 32'h0;
        for (int i = 0; i < 14; i++) msg[i] = words[i];
        msg[14] = 32'h80000000;
        msg[31] = 32'h000001c0;
    endtask

    task automatic launch(input int nb, input bit d);
        @(negedge clk);
        start = 1'b1;
        nblocks = 2'(nb);
        dbl = d;
        hash_ready = 1'b0;
        m_valid = 1'b0;
        @(posedge clk);
    endtask

    // Feeds words until the digest appears; returns observations only, tests compare them.
    task automatic body(input int stall_pct, input int pulse_at, input int abort_at, input int nwords,
                        output logic [255:0] got, output int lat, output int stalls,
                        output int acc, output int extra);
        int cyc;
        bit fin;
        cyc = 0; fin = 0; stalls = 0; acc = 0; extra = 0; lat = -1; got = '0;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            hash_ready = 1'b0;
            start = (cyc == pulse_at);
            if (cyc == pulse_at) begin
                nblocks = 2'd3;
                dbl = 1'b1;
            end
            m_valid = 1'b0;
            if (cyc == abort_at) begin
                fin = 1;
                lat = cyc;
            end else if (hash_valid) begin
                fin = 1;
                lat = cyc;
                got = hash;
            end else if (m_ready) begin
                if (acc >= nwords) begin
                    extra++;
                end else begin
                    m_valid = ($urandom_range(99) >= stall_pct);
                    M = msg[acc];
                    if (m_valid) acc++;
                    else stalls++;
                end
            end
        end
    endtask

    task automatic accept(input bit next_start, input int nb, input bit d);
        hash_ready = 1'b1;
        start = next_start;
        nblocks = 2'(nb);
        dbl = d;
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({busy, m_ready, hash_valid} !== 3'b000 || hash !== '0) begin
            bad++;
            $display("FAIL reset_state: busy=%b m_ready=%b hash_valid=%b hash=%h expected all zero",
                     busy, m_ready, hash_valid, hash);
        end
    endtask

    task automatic run_known(input string name, input int nb, input bit d, input int stall_pct,
                             input int nwords, input logic [255:0] exp_h, input int exp_lat_base);
        logic [255:0] got;
        int lat, stalls, acc, extra;
        launch(nb, d);
        body(stall_pct, -1, -1, nwords, got, lat, stalls, acc, extra);
        total++;
        if (got !== exp_h) begin
            bad++;
            $display("FAIL %s_hash: got %h expected %h", name, got, exp_h);
        end
        total++;
        if (lat !== exp_lat_base + stalls) begin
            bad++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat_base + stalls);
        end
        total++;
        if (acc !== nwords || extra !== 0) begin
            bad++;
            $display("FAIL %s_words: accepted %0d extra_ready %0d expected %0d and 0", name, acc, extra, nwords);
        end
        accept(1'b0, 0, 1'b0);
    endtask

    task automatic test_abc();
        set_abc();
        run_known("abc", 1, 1'b0, 0, 16, ABC_H, 66);
    endtask

    task automatic test_abc_dbl();
        set_abc();
        run_known("abc_dbl", 1, 1'b1, 0, 16, ABCD_H, 131);
    endtask

    task automatic test_two_block();
        set_two();
        run_known("two_block", 2, 1'b0, 0, 32, TWO_H, 131);
    endtask

    task automatic test_nblocks_clamp();
        set_abc();
        run_known("nblocks0", 0, 1'b0, 0, 16, ABC_H, 66);
        set_two();
        run_known("nblocks3", 3, 1'b0, 0, 32, TWO_H, 131);
    endtask

    task automatic test_empty_stall_hold();
        logic [255:0] got;
        int lat, stalls, acc, extra, held_bad;
        for (int i = 0; i < 64; i++) msg[i] = 32'h0;
        msg[0] = 32'h80000000;
        launch(1, 1'b0);
        body(50, -1, -1, 16, got, lat, stalls, acc, extra);
        total++;
        if (got !== EMPTY_H) begin
            bad++;
            $display("FAIL empty_hash: got %h expected %h", got, EMPTY_H);
        end
        total++;
        if (lat !== 66 + stalls) begin
            bad++;
            $display("FAIL empty_latency: got %0d expected %0d", lat, 66 + stalls);
        end
        held_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (hash_valid !== 1'b1 || hash !== EMPTY_H) held_bad++;
        end
        total++;
        if (held_bad !== 0) begin
            bad++;
            $display("FAIL empty_hold: %0d unstable cycles, expected 0", held_bad);
        end
        accept(1'b0, 0, 1'b0);
        @(negedge clk);
        total++;
        if (hash_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL empty_release: hash_valid=%b busy=%b expected 0 0", hash_valid, busy);
        end
    endtask

    task automatic test_start_ignored();
        logic [255:0] got;
        int lat, stalls, acc, extra;
        set_abc();
        launch(1, 1'b0);
        body(0, 20, -1, 16, got, lat, stalls, acc, extra);
        total++;
        if (got !== ABC_H || lat !== 66) begin
            bad++;
            $display("FAIL start_ignored: hash %h latency %0d expected %h 66", got, lat, ABC_H);
        end
        accept(1'b0, 0, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [255:0] got;
        int lat, stalls, acc, extra;
        set_abc();
        launch(1, 1'b0);
        body(0, -1, 30, 16, got, lat, stalls, acc, extra);
        rst = 1'b0;
        #1;
        total++;
        if ({busy, m_ready, hash_valid} !== 3'b000 || hash !== '0) begin
            bad++;
            $display("FAIL async_reset: busy=%b m_ready=%b hash_valid=%b hash=%h expected all zero",
                     busy, m_ready, hash_valid, hash);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_known("after_reset", 1, 1'b0, 0, 16, ABC_H, 66);
    endtask

    task automatic test_back_to_back();
        logic [255:0] got;
        int lat, stalls, acc, extra;
        set_abc();
        launch(1, 1'b0);
        body(0, -1, -1, 16, got, lat, stalls, acc, extra);
        total++;
        if (got !== ABC_H) begin
            bad++;
            $display("FAIL b2b_first: got %h expected %h", got, ABC_H);
        end
        accept(1'b1, 1, 1'b1);
        body(0, -1, -1, 16, got, lat, stalls, acc, extra);
        total++;
        if (got !== ABCD_H || lat !== 131) begin
            bad++;
            $display("FAIL b2b_second: hash %h latency %0d expected %h 131", got, lat, ABCD_H);
        end
        accept(1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [255:0] got, exp_h;
        int lat, stalls, acc, extra, nb, ne, pct;
        bit d;
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 64; i++) msg[i] = $urandom;
            nb = $urandom_range(3);
            d = 1'($urandom_range(1));
            pct = $urandom_range(40);
            ne = eff_blocks(nb);
            exp_h = ref_hash(nb, d);
            launch(nb, d);
            body(pct, -1, -1, 16 * ne, got, lat, stalls, acc, extra);
            total++;
            if (got !== exp_h) begin
                bad++;
                $display("FAIL random_hash[%0d]: nb=%0d dbl=%0d got %h expected %h", j, nb, d, got, exp_h);
            end
            total++;
            if (lat !== 1 + 65 * (ne + int'(d)) + stalls || acc !== 16 * ne || extra !== 0) begin
                bad++;
                $display("FAIL random_flow[%0d]: latency %0d accepted %0d extra %0d expected %0d %0d 0",
                         j, lat, acc, extra, 1 + 65 * (ne + int'(d)) + stalls, 16 * ne);
            end
            accept(1'b0, 0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        nblocks = 2'd0;
        dbl = 1'b0;
        m_valid = 1'b0;
        M = 32'h0;
        hash_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        rst = 1'b1;
        test_abc();
        test_abc_dbl();
        test_two_block();
        test_empty_stall_hold();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        test_nblocks_clamp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha_multiblock_core.md
Name: sha_multiblock_core

Overview:
- Parametrised SHA-256 engine computing one round per cycle over 1..MAX_BLOCKS caller-supplied, pre-padded 512-bit blocks.
- Optional in-core double hash (sha256d): the first digest is re-hashed as a 256-bit message with internally generated padding.
- Valid/ready handshakes on message words and on the digest, so upstream and downstream may stall freely.
- Sits between the work/nonce formatter and the target comparator.

Parameters:
MAX_BLOCKS, 2, maximum caller-supplied blocks per job
BLKW, 2, width of nblocks port; must hold MAX_BLOCKS
DOUBLE, 1, 1 = dbl mode supported; 0 = dbl ignored and that logic removed

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
start  input  1  job request; sampled with nblocks and dbl
nblocks  input  BLKW  caller block count; 0 treated as 1, >MAX_BLOCKS clamped
dbl  input  1  1 = re-hash the first digest (sha256d)
busy  output  1  high whenever state != IDLE
m_valid  input  1  message word M valid
m_ready  output  1  core accepts M this cycle
M  input  32  message word, big-endian, W[0] first
hash  output  HashState  digest (a..h = H0..H7)
hash_valid  output  1  digest valid; held until accepted
hash_ready  input  1  downstream accepts digest

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, m_ready, hash_valid = 0; hash, working vars, H, W window, counters = 0.
- States: IDLE, LOAD, EXPAND, FINAL, DONE.
- IDLE: start=1 latches the clamped block count and dbl&DOUBLE; H loaded with the IV, working vars a..h = IV, round t=0, blk=0; next state LOAD.
- LOAD: m_ready=1. On each m_valid&m_ready, W[t]=M, one round executes, t++. With m_valid=0 the core stalls (no state change). After t=15 -> EXPAND.
- EXPAND: W[t] = s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] from a 16-word shift window; one round per cycle for t=16..63, then FINAL.
- FINAL (1 cycle): H += a..h, all mod 2^32 per word. Then:
  - blk+1 < total caller blocks: blk++, a..h=H, t=0, go to LOAD.
  - Caller blocks finished, dbl set, and the second pass has not started: latch the digest as message words 0..7. Words 8..15 = 80000000, six words of 00000000, 00000100. H and a..h reset to the IV, go to LOAD with m_ready forced 0; words are fed internally, one per cycle, no stall.
  - Otherwise: hash=H, go to DONE.
- DONE: hash_valid=1 and hash stable. hash_ready=1 -> IDLE. hash_ready=1 together with start=1 accepts the new job directly (same transition as IDLE+start).
- Latency, no stalls: start sampled at edge 0, first word accepted in cycle 1, hash_valid first high in cycle 1+65*(nblocks_eff+dbl_eff). One block = 66; sha256d of one block = 131.
- start while busy (other than DONE+hash_ready) is ignored. m_valid outside LOAD is ignored (m_ready=0).
- Async reset mid-job aborts everything; the core returns to the reset values above with no partial digest ever presented.
- Arithmetic: all additions 32-bit, carries discarded. Round uses Ch, Maj, S0, S1, K[t] from the package.

Decomposition:
- Shared package sha_pkg holds: HashState (existing), K[0:63] constant array, IV constant, sigma/Sigma functions, state enum, second-pass padding constants.
- One sub-module: sha_round_step. Purely combinational: (HashState in, W, K) -> HashState out. Reused by later multi-round variants.

Test Plan:
- "abc" (61626380, fourteen 00000000, 00000018), nblocks=1, dbl=0, m_valid always 1 -> hash_valid at cycle 66, hash = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Same block, dbl=1 -> hash_valid at cycle 131, hash = 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358; m_ready stays 0 throughout the second pass.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", nblocks=2 -> hash_valid at cycle 131, hash = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Empty message (80000000, fifteen 00000000) with m_valid randomly low ~50% and hash_ready held 0 for 10 cycles:
  - hash = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
  - hash_valid stays high and hash stays stable until hash_ready.
  - Latency = 66 + number of stall cycles.
- start pulsed mid-job -> ignored, result unchanged. rst=0 asserted at cycle 30 -> busy, m_ready, hash_valid = 0 and hash = 0 immediately (async). The next job after release gives the correct "abc" digest.
- DONE with hash_ready=1 and start=1 in the same cycle -> new job accepted without an IDLE cycle. nblocks=0 behaves as 1; nblocks=3 with MAX_BLOCKS=2 consumes only 32 words.
